// File: rtl/ring_router_demux_pkg.sv
// Shared types for the ring router ingress demux: flit width and the
// destination-match helper used when a packet header arrives.
package ring_router_demux_pkg;

    localparam int DATA_W = 16;

    typedef logic [DATA_W-1:0] flit_data_t;

    function automatic logic isLocalDest(input flit_data_t dest, input flit_data_t id);
        return dest == id;
    endfunction

endpackage

// File: rtl/ring_router_demux_if.sv
// DII stream channel: one flit per valid/ready handshake, with packet
// boundaries marked by first/last.
interface dii_channel;
    import ring_router_demux_pkg::*;

    logic       valid;
    logic       ready;
    flit_data_t data;
    logic       first;
    logic       last;

    modport master (output valid, data, first, last, input ready);
    modport slave  (input valid, data, first, last, output ready);

endinterface

// File: rtl/ring_router_demux_oreg.sv
// One-flit output register slice: fully registered outputs, and it can take
// a new flit in the same cycle the held one drains.
module ring_router_demux_oreg
    import ring_router_demux_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  flit_data_t data_i,
    input  logic       first_i,
    input  logic       last_i,
    output logic       canTake_o,
    dii_channel.master out_o
);

    logic       valid_q;
    flit_data_t data_q;
    logic       first_q;
    logic       last_q;

    // load is only raised when canTake_o is high, so a held flit is never overwritten
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            first_q <= first_i;
            last_q  <= last_i;
        end else if (out_o.ready) begin
            valid_q <= 1'b0;
        end
    end

    assign canTake_o   = !valid_q || out_o.ready;
    assign out_o.valid = valid_q;
    assign out_o.data  = data_q;
    assign out_o.first = first_q;
    assign out_o.last  = last_q;

endmodule

// File: rtl/ring_router_demux.sv
// Ingress demux of a ring router: steers whole packets (wormhole) either to
// the local endpoint or back onto the ring, based on the header flit.
module ring_router_demux
    import ring_router_demux_pkg::*;
#(
    parameter flit_data_t ID = 16'h0000
) (
    input  logic       clk,
    input  logic       rst,
    dii_channel.slave  in_i,
    dii_channel.master out_local_o,
    dii_channel.master out_ring_o
);

    typedef enum logic [1:0] {
        IDLE,
        WORM_LOCAL,
        WORM_RING
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   inReady;
    logic   loadLocal;
    logic   loadRing;
    logic   localCanTake;
    logic   ringCanTake;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Orphan flits in IDLE are swallowed so the stream resyncs on the next header
    always_comb begin
        state_d   = state_q;
        inReady   = 1'b0;
        loadLocal = 1'b0;
        loadRing  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_i.valid) begin
                    if (!in_i.first) begin
                        inReady = 1'b1;
                    end else if (isLocalDest(in_i.data, ID)) begin
                        inReady   = localCanTake;
                        loadLocal = localCanTake;
                        if (localCanTake && !in_i.last) begin
                            state_d = WORM_LOCAL;
                        end
                    end else begin
                        inReady  = ringCanTake;
                        loadRing = ringCanTake;
                        if (ringCanTake && !in_i.last) begin
                            state_d = WORM_RING;
                        end
                    end
                end
            end
            WORM_LOCAL: begin
                inReady   = localCanTake;
                loadLocal = in_i.valid && localCanTake;
                if (loadLocal && in_i.last) begin
                    state_d = IDLE;
                end
            end
            WORM_RING: begin
                inReady  = ringCanTake;
                loadRing = in_i.valid && ringCanTake;
                if (loadRing && in_i.last) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_i.ready = inReady;

    ring_router_demux_oreg uLocalReg (
        .clk       (clk),
        .rst       (rst),
        .load_i    (loadLocal),
        .data_i    (in_i.data),
        .first_i   (in_i.first),
        .last_i    (in_i.last),
        .canTake_o (localCanTake),
        .out_o     (out_local_o)
    );

    ring_router_demux_oreg uRingReg (
        .clk       (clk),
        .rst       (rst),
        .load_i    (loadRing),
        .data_i    (in_i.data),
        .first_i   (in_i.first),
        .last_i    (in_i.last),
        .canTake_o (ringCanTake),
        .out_o     (out_ring_o)
    );

endmodule

// File: doc/ring_router_demux.md
# ring_router_demux

Splits one DII packet stream into two: packets addressed to this router's local endpoint go to `out_local`, all others go to `out_ring`. Routing is per packet (wormhole); the destination is taken from the first flit. The block sits on the ingress side of each ring router, opposite the mux that merges local and ring traffic onto the egress link. Each output has a one-flit register stage, so neither output port has a combinational path from `in`.

## Interface
Parameters:
- `ID`, default 16'h0000: local endpoint address. A first flit with `data == ID` routes the packet to `out_local`.

Ports:
- `clk`  input  1: single clock, all logic on rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `in`  dii_channel  (valid, ready, data[15:0], first, last): input stream. Block drives `ready`.
- `out_local`  dii_channel  same fields: packets for `ID`. Block drives valid/data/first/last.
- `out_ring`  dii_channel  same fields: all other packets.

## Operation
- State machine: IDLE, WORM_LOCAL, WORM_RING. Reset state is IDLE.
- Per-output register (oreg):
  - Fields: `v`, `data`, `first`, `last`. All are 0 at reset.
  - `can_take = !v || out.ready`.
  - Output pins show the register directly: `out.valid = v`, and likewise for the other fields.
- IDLE, `in.valid && in.first`:
  - Target is local if `in.data == ID` (16-bit exact compare), else ring.
  - `in.ready = target.can_take`.
  - On handshake, the flit loads into the target oreg.
  - If `!in.last`, go to WORM_LOCAL or WORM_RING. If `in.last` (single-flit packet), stay in IDLE.
- IDLE, `in.valid && !in.first`:
  - Orphan flit. `in.ready = 1`, and the flit is discarded.
  - The state machine resynchronises on the next first flit.
- WORM_x:
  - `in.ready = x.can_take`. Every accepted flit loads into oreg x, whatever the value of `first`.
  - Accepting a flit with `last` returns to IDLE.
- `in.ready` is never 1 for the non-target output's space. The other output drains independently.
- An oreg holds its contents while `v && !out.ready`. It clears `v` when it drains with no new load in the same cycle.
- Reset mid-packet: state returns to IDLE and both oregs are invalidated. Partial packets are lost, and downstream receivers must tolerate orphan flits.

## Timing
- Latency: a flit accepted on `in` in cycle N appears on its output in cycle N+1.
- Throughput: one flit per cycle per output, as long as the target `out.ready` stays high. A full oreg accepts a new flit in the same cycle it drains.
- `in.ready` depends combinationally on the target `out.ready` and on `v`. The `out.*` pins are fully registered.
- Head-of-line blocking:
  - A stalled target blocks `in`, including any following packet bound for the other output.
  - The non-target oreg still drains.
- Back-to-back packets: a `last` flit in cycle N and a first flit for the other output in cycle N+1 are both accepted with no bubble.
- Stream protocol: a flit is transferred when `valid && ready` is high on a rising edge. The block keeps its outputs stable while `valid && !ready`.

## Structure
- State enum: local to the module.
- `dii_channel`: the existing shared interface. No new package content.
- Sub-module `ring_router_demux_oreg`:
  - One-flit register slice with `load`, flit inputs, `can_take` output, and a `dii_channel` output.
  - Instantiated twice, once for local and once for ring.

## Test plan
- Reset, then idle: all `out.valid = 0` and all oreg fields = 0, with `in.ready` high only for orphans. Drive a single flit {data=ID, first=1, last=1} with `ID=16'h0005` -> `out_local` shows data=5, first=1, last=1 one cycle later; `out_ring.valid` stays 0.
- 4-flit packet with dest 16'h0007 and `ID=5`, outputs always ready -> flits appear on `out_ring` in cycles N+1..N+4 with first/last on flits 1 and 4; state returns to IDLE.
- Alternating single-flit packets (dest 5, 7, 5, 7) streamed back-to-back -> each flit is accepted every cycle and alternates between local and ring; no bubbles.
- Hold `out_local.ready=0` while sending a 3-flit local packet -> the first flit sits in the oreg and `in.ready` drops on flit 2. Raising ready releases flits 2-3 at one per cycle. A ring packet queued behind it waits, then passes.
- Orphan flit (first=0) in IDLE -> accepted and dropped, no output valid. A following first flit routes normally.
- Assert `rst` after flit 2 of a 4-flit ring packet -> next cycle state is IDLE and both `out.valid = 0`. Flits 3-4 are treated as orphans and dropped.
